conv_apb_host: RTL and testbench
================================

// Module: conv_apb_host
// PURPOSE
//  APB requester that programs and monitors the conv accelerator's APB register slave.
//  - Takes single-beat commands (write, read, or poll-until-match) from a local sequencer.
//  - Runs compliant SETUP/ACCESS transfers with wait-state support, then returns one
//    response per command.
//  - Poll mode: re-reads a status register (e.g. conv_done) until a masked compare matches
//    or a read limit is reached.
// PARAMETERS
//  ADDR_WIDTH  32    PADDR / cmd_addr width
//  DATA_WIDTH  32    PWDATA / PRDATA / cmd data width
//  POLL_GAP    4     idle cycles (PSEL=0) between consecutive poll reads; legal range >=1
//  POLL_LIMIT  1024  max poll reads before timeout; legal range >=1
// PORTS
//  PCLK         in   1           clock, rising edge
//  PRESETB      in   1           async active-low reset
//  cmd_valid    in   1           command present
//  cmd_ready    out  1           1 only in IDLE; command accepted on cmd_valid&cmd_ready
//  cmd_write    in   1           1=write, 0=read
//  cmd_poll     in   1           1=poll read (ignored when cmd_write=1)
//  cmd_addr     in   ADDR_WIDTH  register address
//  cmd_wdata    in   DATA_WIDTH  write data; in poll mode, the expected value
//  cmd_mask     in   DATA_WIDTH  poll compare mask (unused otherwise)
//  rsp_valid    out  1           one-cycle response pulse, no backpressure
//  rsp_rdata    out  DATA_WIDTH  last PRDATA captured (0 for writes)
//  rsp_err      out  1           PSLVERR seen on the final transfer
//  rsp_timeout  out  1           poll ended without a match
//  PADDR        out  ADDR_WIDTH  APB address
//  PSEL         out  1           APB select
//  PENABLE      out  1           APB enable
//  PWRITE       out  1           APB direction
//  PWDATA       out  DATA_WIDTH  APB write data
//  PRDATA       in   DATA_WIDTH  APB read data
//  PREADY       in   1           APB ready; low inserts wait states
//  PSLVERR      in   1           APB error, sampled with PREADY=1
// BEHAVIOUR
//  Reset values: all outputs 0 except cmd_ready=1 (state IDLE); poll counter 0.
//  States:
//   - IDLE:   cmd_ready=1. On accept, latch cmd_* and go to SETUP.
//   - SETUP:  PSEL=1, PENABLE=0. Next state is ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1. Hold while PREADY=0. On PREADY=1 the transfer completes.
//   - GAP:    PSEL=0, PENABLE=0 for POLL_GAP cycles, then SETUP.
//  Bus signal stability: PADDR, PWRITE and PWDATA are driven from the latched command in
//   SETUP and stay constant through ACCESS, including wait states. Outside a transfer they
//   hold their last value.
//  Transfer completion (all outputs registered):
//   - Write or plain read: rsp_valid=1 next cycle with rsp_rdata=PRDATA (0 for writes),
//     rsp_err=PSLVERR, rsp_timeout=0. State returns to IDLE.
//   - Poll read, PSLVERR=1: respond err=1, timeout=0. Polling stops.
//   - Poll read, (PRDATA&cmd_mask)==(cmd_wdata&cmd_mask): respond err=0, timeout=0.
//   - Poll read, no match: poll counter increments. If the count reaches POLL_LIMIT,
//     respond timeout=1 with rsp_rdata = last PRDATA. Otherwise go to GAP.
//   - The poll counter clears on command accept. Width is $clog2(POLL_LIMIT+1).
//  Latency, zero-wait write: accept cycle T, SETUP T+1, ACCESS T+2, rsp_valid and cmd_ready
//   in T+3. A new command may be accepted at T+3 with SETUP at T+4. Best-case throughput is
//   one transfer per 3 cycles.
//  Boundary conditions:
//   - Only one command is outstanding. cmd_valid while busy is not accepted.
//   - rsp_valid is high in the same cycle that cmd_ready returns to 1.
//   - PSLVERR is ignored while PREADY=0.
//   - A poll that matches on the read that reaches POLL_LIMIT reports a match, not a timeout.
//  Reset mid-operation: PSEL and PENABLE drop to 0 asynchronously, no response is issued,
//   and the state returns to IDLE. The aborted command is lost.
// TESTING
//  1. Write addr 0x04, data 0x5, PREADY=1 -> PSEL=1 at T+1, PENABLE=1 at T+2,
//     rsp_valid=1 at T+3 with err=0, timeout=0.
//  2. Read addr 0x08 with PREADY low 3 cycles, then PRDATA=0x1234 -> ACCESS lasts 4 cycles
//     with PADDR stable, rsp_rdata=0x1234.
//  3. Read with PSLVERR=1 and PRDATA=0xDEAD -> rsp_err=1, rsp_rdata=0xDEAD, one rsp pulse.
//  4. Poll mask=0x2, expect=0x2, slave returns 0,0,0x2 -> exactly 3 transfers separated by
//     4 idle cycles, rsp_rdata=0x2, timeout=0.
//  5. POLL_LIMIT=8, slave always returns 0 -> exactly 8 reads, rsp_timeout=1, rsp_rdata=0.
//  6. Assert PRESETB low during ACCESS -> PSEL=0 immediately, no rsp_valid, cmd_ready=1
//     after release; next write completes normally.

Source files
------------

// File: rtl/conv_apb_host_if.sv
// Command/response and APB signal bundle for the conv accelerator APB host.
// master = the host; slave = the sequencer plus register slave driving the other side.
interface conv_apb_host_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic                  cmd_poll;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] cmd_mask;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_poll, cmd_addr, cmd_wdata, cmd_mask,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/conv_apb_host.sv
// APB requester: single-beat write/read, plus poll-until-masked-match with an idle gap
// between reads and a read limit. One command outstanding, one response pulse per command.
module conv_apb_host #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 1024
) (
  input logic                PCLK,
  input logic                PRESETB,
  conv_apb_host_if.master    bus
);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [CW-1:0] LIMIT    = CW'(POLL_LIMIT);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, mask_q, rdata_q;
  logic                  write_q, poll_q;
  logic [CW-1:0]         poll_cnt, cnt_nxt;
  logic [GW-1:0]         gap_cnt;
  logic                  rsp_valid_q, rsp_err_q, rsp_to_q;
  logic                  accept, xfer_done, match, finish;

  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign xfer_done = (state == ACCESS) && bus.PREADY;
  assign match     = ((bus.PRDATA ^ wdata_q) & mask_q) == '0;
  assign cnt_nxt   = poll_cnt + 1'b1;
  // A match or error on the limit-reaching read wins over the timeout.
  assign finish    = xfer_done && (!poll_q || bus.PSLVERR || match || cnt_nxt == LIMIT);

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done) state_nxt = finish ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = SETUP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      write_q     <= 1'b0;
      poll_q      <= 1'b0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (accept) begin
        addr_q   <= bus.cmd_addr;
        wdata_q  <= bus.cmd_wdata;
        mask_q   <= bus.cmd_mask;
        write_q  <= bus.cmd_write;
        poll_q   <= bus.cmd_poll & ~bus.cmd_write;
        poll_cnt <= '0;
      end else if (xfer_done && poll_q && !finish) begin
        poll_cnt <= cnt_nxt;
      end
      gap_cnt     <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      rsp_valid_q <= finish;
      if (finish) begin
        rdata_q   <= write_q ? '0 : bus.PRDATA;
        rsp_err_q <= bus.PSLVERR;
        rsp_to_q  <= poll_q && !bus.PSLVERR && !match;
      end
    end
  end

  // PSEL/PENABLE decode straight from the state flop so reset drops them immediately.
  assign bus.PSEL        = (state == SETUP) || (state == ACCESS);
  assign bus.PENABLE     = (state == ACCESS);
  assign bus.PADDR       = addr_q;
  assign bus.PWRITE      = write_q;
  assign bus.PWDATA      = wdata_q;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
endmodule

// File: tb/tb_conv_apb_host.sv
// Directed bench for conv_apb_host: write, wait-state read, error read, poll match,
// poll timeout, match on the last allowed read, and reset during ACCESS.
module tb_conv_apb_host;
  logic PCLK = 1'b0;
  logic PRESETB = 1'b0;
  int   errors = 0;
  int   checks = 0;

  conv_apb_host_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  conv_apb_host #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .POLL_GAP(4), .POLL_LIMIT(8)) dut (
    .PCLK(PCLK), .PRESETB(PRESETB), .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  // Register slave: directed PRDATA, or a per-read table while polling.
  logic [31:0] prdata_drv = '0;
  logic [31:0] poll_data [16];
  logic        model_on = 1'b0;
  int          xfers = 0;
  int          base = 0;
  logic [3:0]  idx;
  assign idx = 4'(xfers - base);
  assign bus.PRDATA = model_on ? poll_data[idx] : prdata_drv;

  always @(posedge PCLK) if (bus.PSEL && bus.PENABLE && bus.PREADY) xfers <= xfers + 1;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic pl, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] m);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_poll = pl;
    bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_mask = m;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_poll(input string tag, input int exp_xfers, input int exp_gaps,
                          input logic [31:0] exp_rdata, input logic exp_to);
    int idle = 0, ngaps = 0;
    logic got = 1'b0;
    base = xfers;
    model_on = 1'b1;
    issue(1'b0, 1'b1, 32'h10, (tag == "poll4") ? 32'h2 : 32'h1, (tag == "poll4") ? 32'h2 : 32'hFF);
    for (int c = 0; c < 200; c++) begin
      if (bus.rsp_valid) begin got = 1'b1; break; end
      if (!bus.PSEL) idle++;
      else if (idle != 0) begin chk({tag, "_gap_len"}, idle, 4); ngaps++; idle = 0; end
      tick();
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_xfers"}, xfers - base, exp_xfers);
    chk({tag, "_ngaps"}, ngaps, exp_gaps);
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, "_timeout"}, bus.rsp_timeout, exp_to);
    chk({tag, "_err"}, bus.rsp_err, 0);
    model_on = 1'b0;
    tick();
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_poll = 1'b0;
    bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_mask = '0;
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    foreach (poll_data[i]) poll_data[i] = '0;
    #12;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_outs", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 0);
    chk("rst_bus", {bus.PADDR, bus.PWDATA}, 0);
    PRESETB = 1'b1;
    tick();

    // 1: zero-wait write
    issue(1'b1, 1'b0, 32'h4, 32'h5, 32'h0);
    chk("wr_setup", {bus.PSEL, bus.PENABLE, bus.cmd_ready}, 3'b100);
    chk("wr_bus", {bus.PADDR, bus.PWDATA, 31'h0, bus.PWRITE}, {32'h4, 32'h5, 32'h1});
    tick();
    chk("wr_access", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b110);
    tick();
    chk("wr_rsp", {bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout, bus.PSEL}, 5'b11000);
    chk("wr_rdata", bus.rsp_rdata, 0);
    tick();
    chk("wr_pulse", bus.rsp_valid, 0);

    // 2: read with 3 wait states; PSLVERR and a new cmd_valid during waits are ignored
    bus.PREADY = 1'b0;
    issue(1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    chk("rd_setup_addr", bus.PADDR, 32'h8);
    tick();
    bus.PSLVERR = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid}, 4'b1100);
      chk("rd_wait_addr", bus.PADDR, 32'h8);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0; prdata_drv = 32'h1234;
    chk("rd_last_access", {bus.PENABLE, bus.PADDR}, {1'b1, 32'h8});
    tick();
    chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b100);
    chk("rd_rdata", bus.rsp_rdata, 32'h1234);
    tick();

    // 3: read with slave error
    bus.PSLVERR = 1'b1; prdata_drv = 32'hDEAD;
    issue(1'b0, 1'b0, 32'hC, 32'h0, 32'h0);
    tick();
    tick();
    chk("err_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 3'b110);
    chk("err_rdata", bus.rsp_rdata, 32'hDEAD);
    bus.PSLVERR = 1'b0;
    tick();
    chk("err_pulse", bus.rsp_valid, 0);

    // 4: poll matches on third read
    poll_data[0] = 32'h0; poll_data[1] = 32'h0; poll_data[2] = 32'h2;
    run_poll("poll4", 3, 2, 32'h2, 1'b0);

    // 5: poll never matches -> timeout after POLL_LIMIT=8 reads
    foreach (poll_data[i]) poll_data[i] = '0;
    run_poll("poll_to", 8, 7, 32'h0, 1'b1);

    // match on the limit-reaching read is a match, not a timeout
    poll_data[7] = 32'h1;
    run_poll("poll_last", 8, 7, 32'h1, 1'b0);

    // 6: reset during ACCESS
    bus.PREADY = 1'b0;
    issue(1'b1, 1'b0, 32'h20, 32'hAA, 32'h0);
    tick();
    chk("rst_mid_access", {bus.PSEL, bus.PENABLE}, 2'b11);
    #2 PRESETB = 1'b0;
    #1;
    chk("rst_mid_drop", {bus.PSEL, bus.PENABLE, bus.rsp_valid}, 3'b000);
    tick();
    PRESETB = 1'b1; bus.PREADY = 1'b1;
    tick();
    chk("rst_mid_after", {bus.cmd_ready, bus.rsp_valid, bus.PSEL}, 3'b100);
    issue(1'b1, 1'b0, 32'h24, 32'h77, 32'h0);
    chk("post_setup", {bus.PSEL, bus.PADDR}, {1'b1, 32'h24});
    tick();
    tick();
    chk("post_rsp", {bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_timeout}, 4'b1100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
